// File: rtl/fibo_pkg.sv
// Shared types and default widths for the fibo datapath (sequencer + Adder).
package fibo_pkg;

  localparam int FIBO_BITS = 32;
  localparam int FIBO_CNTW = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } fibo_state_t;

endpackage

// File: rtl/fibo_sequencer.sv
// Fibonacci controller that sequences one shared two-operand Adder through IEA/IEB/OE.
// Optional sticky wrap flag OVF is built only when FIBO_OVF_EN is defined.
module fibo_sequencer
  import fibo_pkg::*;
#(
  parameter int BITS = FIBO_BITS,
  parameter int CNTW = FIBO_CNTW
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [CNTW-1:0] N,
  output logic            BUSY,
  output logic            DONE,
  output logic [BITS-1:0] FIB,
  output logic            FIB_VALID,
  output logic [BITS-1:0] ADD_A,
  output logic [BITS-1:0] ADD_B,
  output logic            ADD_IEA,
  output logic            ADD_IEB,
  input  logic [BITS-1:0] ADD_Y,
  input  logic            ADD_OE,
`ifdef FIBO_OVF_EN
  output logic            OVF,
`endif
  output logic [2:0]      STATE
);

  // Adder handshake: operands are taken when IEA=IEB=1 for one cycle (ISSUE only);
  // the sum is valid while ADD_OE=1, and OE clears a cycle after it is seen with the
  // enables low. DRAIN waits for OE=0 so a stale result is never consumed in WAIT.

  fibo_state_t     state_q, state_d;
  logic [BITS-1:0] prev_q, cur_q, fib_q;
  logic [CNTW-1:0] k_q, n_q;
  logic [CNTW-1:0] k_next;
  logic            accept;
  logic            capture;

  assign k_next  = k_q + CNTW'(1);
  assign accept  = (state_q == S_IDLE) && START;
  assign capture = (state_q == S_WAIT) && ADD_OE;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START) state_d = (N < CNTW'(2)) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (!ADD_OE) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (ADD_OE) state_d = (k_next == n_q) ? S_DONE : S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state_q != S_IDLE);
    DONE      = (state_q == S_DONE);
    ADD_IEA   = (state_q == S_ISSUE);
    ADD_IEB   = (state_q == S_ISSUE);
    FIB_VALID = capture;
    ADD_A     = prev_q;
    ADD_B     = cur_q;
    FIB       = fib_q;
    STATE     = state_q;
  end

  // cur resets to 0 so ADD_B idles at 0; the F(1)=1 seed is loaded on START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= '0;
      cur_q  <= '0;
      fib_q  <= '0;
      k_q    <= '0;
      n_q    <= '0;
    end else if (accept) begin
      n_q    <= N;
      prev_q <= '0;
      cur_q  <= BITS'(1);
      k_q    <= CNTW'(1);
      fib_q  <= (N == CNTW'(1)) ? BITS'(1) : '0;
    end else if (capture) begin
      prev_q <= cur_q;
      cur_q  <= ADD_Y;
      fib_q  <= ADD_Y;
      k_q    <= k_next;
    end
  end

`ifdef FIBO_OVF_EN
  logic ovf_q;

  // A sum smaller than its larger operand means the adder wrapped.
  always_ff @(posedge CLK) begin
    if (RST || accept)              ovf_q <= 1'b0;
    else if (capture && ADD_Y < cur_q) ovf_q <= 1'b1;
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: doc/fibo_sequencer.md
# fibo_sequencer

Controller that computes the Fibonacci term F(N) by sequencing the shared two-operand `Adder` block through its `IEA`/`IEB`/`OE` handshake. It sits between a host START/DONE interface and one `Adder` instance, owns both operand registers, and emits every intermediate term as it is produced. It is the control half of the fibo datapath.

## Interface
- `BITS`, 32, width of operands, sum and result; must match the attached `Adder`.
- `CNTW`, 8, width of the term index `N`.
- `CLK`  in  1  system clock, all logic on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  sampled only in IDLE; begins computing F(`N`).
- `N`  in  CNTW  term index, captured on the accepted START.
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle pulse when `FIB` holds F(N).
- `FIB`  out  BITS  latest term produced; holds value until next START.
- `FIB_VALID`  out  1  one-cycle pulse per new term written to `FIB`.
- `ADD_A`, `ADD_B`  out  BITS  operands to the adder.
- `ADD_IEA`, `ADD_IEB`  out  1  operand enables; always driven identically.
- `ADD_Y`  in  BITS  adder sum.
- `ADD_OE`  in  1  adder result-valid.
- `OVF`  out  1  sticky overflow flag (only with `FIBO_OVF_EN`).

## Operation
- Registers: `prev` = F(k-1), `cur` = F(k), `k`, captured `n`.
- States: IDLE, DRAIN, ISSUE, WAIT, DONE.
- IDLE: `START` captures `N`, loads prev=0, cur=1, k=1.
  - N=0: go to DONE with `FIB`=0. Adder is not used.
  - N=1: go to DONE with `FIB`=1. Adder is not used.
  - Otherwise: go to DRAIN.
- DRAIN: drive IEA=IEB=0. Stay while `ADD_OE`=1. When `ADD_OE`=0, go to ISSUE. DRAIN guarantees the adder is back in its init state, because the adder clears OE one cycle after the enables drop.
- ISSUE: one cycle; ADD_A=prev, ADD_B=cur, IEA=IEB=1; go to WAIT.
- WAIT: enables low; operands held. On `ADD_OE`=1:
  - prev<=cur, cur<=ADD_Y, FIB<=ADD_Y, FIB_VALID pulse, k<=k+1.
  - If k+1==n, go to DONE; else go to DRAIN.
- DONE: one cycle with DONE=1, then IDLE. START arriving in DONE is ignored.
- Arithmetic: modulo 2^BITS; the carry-out is discarded by the adder.
- `ADD_OE` is ignored in IDLE and DONE, including X from the unreset adder.
- IEA and IEB are never asserted outside ISSUE. This means the adder's single-operand states StA/StB are never entered.

## Timing
- Reset values: BUSY=0, DONE=0, FIB=0, FIB_VALID=0, ADD_A=0, ADD_B=0, ADD_IEA=0, ADD_IEB=0, OVF=0; state IDLE.
- Reset mid-operation: enables drop in the same cycle. The adder has no reset and self-clears once OE=1 with enables low. The next START passes through DRAIN, so no stale `ADD_OE` is consumed.
- Per addition: DRAIN ≥1 cycle, ISSUE 1 cycle, WAIT until OE (2 cycles with the current adder). Latency per addition is 4 cycles minimum, plus any extra DRAIN cycles.
- The first DRAIN after START completes in 1 cycle if the adder is idle.
- F(N) for N≥2 takes exactly N-1 adder transactions and gives N-1 FIB_VALID pulses.
- DONE is asserted the cycle after the final FIB_VALID.
- N=0 and N=1: DONE is asserted 1 cycle after START.

## Configuration
- `FIBO_OVF_EN`
  - Defined: in WAIT, if ADD_Y < cur (unsigned wrap), OVF is set. OVF is sticky until the next accepted START or RST. Computation continues and produces wrapped values.
  - Undefined: no `OVF` port, no compare logic.

## Structure
- Package `fibo_pkg`: state enum {IDLE, DRAIN, ISSUE, WAIT, DONE}, and default BITS/CNTW constants shared with `Adder` instantiation.
- No sub-module inside the controller. A wrapper `fibo_top` instantiates `fibo_sequencer` and `Adder` for the bench.

## Test plan
- Reset, START with N=0 → DONE after 1 cycle, FIB=0, no FIB_VALID, ADD_IEA never high.
- START with N=10 → exactly 9 FIB_VALID pulses with FIB = 1,2,3,5,8,13,21,34,55; DONE with FIB=55.
- START with N=1 → DONE, FIB=1; then immediately START with N=2 → one pulse, FIB=1, DONE.
- Assert RST while in WAIT during N=20 → outputs return to reset values. Then START with N=5 → FIB=5, with no early capture from stale ADD_OE.
- BITS=8, `FIBO_OVF_EN` defined, N=14 → F(13)=233 with OVF=0, then FIB=377 mod 256=121 with OVF=1. OVF is cleared by the next START.
- Assertion checks, every run:
  - ADD_IEA==ADD_IEB at all times.
  - Enables are high only in ISSUE, and only when ADD_OE was sampled 0 in the preceding DRAIN.
